// File: rtl/encoder8_3_serial.sv
// Serial 8-to-3 encoder: captures a request vector and emits each set line's index over valid/ready.
// Optional round-robin selection is enabled by defining ENC_ROUND_ROBIN_EN; otherwise lowest index wins.
module encoder8_3_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       Ena,
    input  logic       load,
    input  logic [7:0] input_line,
    input  logic       ready,
    output logic [2:0] output_line,
    output logic       valid,
    output logic       busy,
    output logic [3:0] pending_cnt,
    output logic       done
);
    localparam int unsigned N_LINES = 8;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N_LINES-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [CODE_W-1:0]   sel;
    logic                hs;

`ifdef ENC_ROUND_ROBIN_EN
    logic [CODE_W-1:0]   ptr_q, ptr_d;
    logic [CODE_W-1:0]   idx;

    // First pending line at or after the pointer, wrapping 7 -> 0; lowest offset wins.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            idx = ptr_q + CODE_W'(i);
            if (pending_q[idx]) begin
                sel = idx;
            end
        end
    end
`else
    // Fixed priority: lowest pending index.
    always_comb begin
        sel = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = CODE_W'(i);
            end
        end
    end
`endif

    assign valid       = Ena && (state_q == EMIT);
    assign output_line = valid ? sel : '0;
    assign hs          = valid && ready;

    assign busy        = busy_q;
    assign pending_cnt = cnt_q;
    assign done        = done_q;

    // Next-state logic; with Ena low everything holds and done drops.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        if (Ena) begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        pending_d = input_line;
                        if (input_line != '0) begin
                            state_d = EMIT;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (hs) begin
                        pending_d[sel] = 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
                        ptr_d = sel + CODE_W'(1);
`endif
                        if (pending_d == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        cnt_d = '0;
        for (int i = 0; i < N_LINES; i++) begin
            cnt_d = cnt_d + CNT_W'(pending_d[i]);
        end
        busy_d = (state_d == EMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef ENC_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_encoder8_3_serial.sv
// Scoreboard bench for encoder8_3_serial: stimulus queues expected codes, a monitor checks them.
module tb_encoder8_3_serial;
    logic       clk = 1'b0;
    logic       rst;
    logic       Ena;
    logic       load;
    logic [7:0] input_line;
    logic       ready;
    logic [2:0] output_line;
    logic       valid;
    logic       busy;
    logic [3:0] pending_cnt;
    logic       done;

    typedef struct packed {
        logic [2:0] code;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    bit   mon_en  = 1'b0;

    encoder8_3_serial dut (
        .clk         (clk),
        .rst         (rst),
        .Ena         (Ena),
        .load        (load),
        .input_line  (input_line),
        .ready       (ready),
        .output_line (output_line),
        .valid       (valid),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, got, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] code, input logic [3:0] cnt);
        exp_t e;
        e.code = code;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic push_a6();
        push(3'd1, 4'd4);
        push(3'd2, 4'd3);
        push(3'd5, 4'd2);
        push(3'd7, 4'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_output_line"}, 32'(output_line), 0);
        chk({tag, "_pending_cnt"}, 32'(pending_cnt), 0);
    endtask

    // Monitor: every presented code must match the head of the scoreboard; pop on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_valid: got code %0d, required no valid at %0t", output_line, $time);
                end else begin
                    chk("code", 32'(output_line), 32'(exp_q[0].code));
                    chk("pending_cnt", 32'(pending_cnt), 32'(exp_q[0].cnt));
                    if (ready === 1'b1) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_output_line", 32'(output_line), 0);
            end
        end
    end

    initial begin
        rst = 1'b1; Ena = 1'b0; load = 1'b0; input_line = '0; ready = 1'b0;

        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            Ena = 1'($urandom); load = 1'($urandom);
            input_line = 8'($urandom); ready = 1'($urandom);
            tick();
            chk_idle_outputs("reset");
            chk("reset_done", 32'(done), 0);
        end
        rst = 1'b0; Ena = 1'b1; load = 1'b0; ready = 1'b1; input_line = '0;
        mon_en = 1'b1;
        tick();

        // Batch with ready held high.
        push_a6();
        load = 1'b1; input_line = 8'hA6;
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("batch_busy", 32'(busy), 1);
        tick(); tick(); tick();
        @(negedge clk);
        chk("batch_done_early", 32'(done), 0);
        tick();
        @(negedge clk);
        chk("batch_done", 32'(done), 1);
        chk("batch_busy_end", 32'(busy), 0);
        chk("batch_valid_end", 32'(valid), 0);
        tick();
        @(negedge clk);
        chk("batch_done_single", 32'(done), 0);

        // Backpressure on the first code, plus an ignored load of 8'hFF while stalled.
        ready = 1'b0;
        push_a6();
        load = 1'b1; input_line = 8'hA6;
        tick();
        load = 1'b0;
        tick();
        load = 1'b1; input_line = 8'hFF;
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("bp_cnt_held", 32'(pending_cnt), 4);
        tick();
        ready = 1'b1;
        tick(); tick(); tick();
        // Load coinciding with the final handshake is ignored.
        load = 1'b1; input_line = 8'h08;
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("bp_done", 32'(done), 1);
        chk("bp_busy_end", 32'(busy), 0);
        tick();
        chk_idle_outputs("final_load_ignored");

        // Empty load: done next cycle, no valid.
        load = 1'b1; input_line = 8'h00;
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("empty_done", 32'(done), 1);
        chk("empty_valid", 32'(valid), 0);
        chk("empty_busy", 32'(busy), 0);
        tick();
        @(negedge clk);
        chk("empty_done_single", 32'(done), 0);

        // Ena freeze mid-batch.
        push_a6();
        load = 1'b1; input_line = 8'hA6;
        tick();
        load = 1'b0;
        tick();
        Ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("freeze_valid", 32'(valid), 0);
            chk("freeze_busy", 32'(busy), 1);
            chk("freeze_cnt", 32'(pending_cnt), 3);
            chk("freeze_done", 32'(done), 0);
            tick();
        end
        Ena = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        chk("freeze_done_end", 32'(done), 1);
        tick();

        // Reset after the second code: batch discarded, no done pulse.
        push_a6();
        load = 1'b1; input_line = 8'hA6;
        tick();
        load = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        chk_idle_outputs("midrst");
        chk("midrst_done", 32'(done), 0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_no_done", 32'(done), 0);
        chk("midrst_busy", 32'(busy), 0);

`ifdef ENC_ROUND_ROBIN_EN
        // Pointer advances past 0, so the next 8'h81 batch starts at 7.
        push(3'd0, 4'd1);
        load = 1'b1; input_line = 8'h01;
        tick();
        load = 1'b0;
        tick();
        push(3'd7, 4'd2);
        push(3'd0, 4'd1);
`else
        push(3'd0, 4'd2);
        push(3'd7, 4'd1);
`endif
        load = 1'b1; input_line = 8'h81;
        tick();
        load = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("sel_done", 32'(done), 1);
        tick(); tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
